// File: rtl/spkey_sequencer.sv
// Purpose : debounces ten special-key levels and turns presses into a single
//           valid/ready event stream (keys 9/10 optionally report long presses).
// Latency : debounced edge in tick cycle N -> pending at N+1 -> evt_valid at N+2.
// Backpressure: one event pending per key; a key re-firing while its pending
//               slot is full is dropped and flagged on evt_ovf for one cycle.
//
// Ports:
//   clk, reset             : rising-edge clock, asynchronous active-high reset
//   spkey_function[10:1]   : raw key levels (1 = pressed), asynchronous to clk
//   evt_valid/evt_ready    : event handshake; code/long held stable until ready
//   evt_code[3:0]          : key index 1..10 of the presented event
//   evt_long               : presented event is a long press
//   keys_db[10:1]          : debounced key levels
//   evt_ovf                : one-cycle pulse when an event is dropped
//
// Build option: define SPKEY_LONGPRESS_EN to give keys 9 and 10 hold counters
// and long-press events; otherwise they behave like keys 1..8.

module spkey_sequencer #(
    parameter int TICK_DIV   = 16384,
    parameter int HOLD_TICKS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:1] spkey_function,
    input  logic        evt_ready,
    output logic        evt_valid,
    output logic [3:0]  evt_code,
    output logic        evt_long,
    output logic [10:1] keys_db,
    output logic        evt_ovf
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [10:1] sync_q1;
    logic [10:1] sync_q2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= spkey_function;
            sync_q2 <= sync_q1;
        end
    end

    // ------------------------------------------------------------------
    // Sample-tick prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: 4-sample history per key, level flips only on 4 agreeing
    // samples, otherwise the previous debounced level is kept.
    // ------------------------------------------------------------------
    logic [10:1][3:0] hist;
    logic [10:1][3:0] hist_nxt;
    logic [10:1]      db_nxt;

    always_comb begin
        hist_nxt = hist;
        db_nxt   = keys_db;
        if (tick) begin
            for (int k = 1; k <= 10; k++) begin
                hist_nxt[k] = {hist[k][2:0], sync_q2[k]};
                if (hist_nxt[k] == 4'b1111) begin
                    db_nxt[k] = 1'b1;
                end else if (hist_nxt[k] == 4'b0000) begin
                    db_nxt[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist    <= '0;
            keys_db <= '0;
        end else begin
            hist    <= hist_nxt;
            keys_db <= db_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Event raising. db_nxt differs from keys_db only in tick cycles, so
    // every raise below is a tick-cycle pulse.
    // ------------------------------------------------------------------
    logic [10:1] raise;
    logic [10:1] raise_long;

`ifdef SPKEY_LONGPRESS_EN
    localparam logic [7:0] HOLD_M1  = 8'(HOLD_TICKS - 1);
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_TICKS);

    logic [10:9][7:0] hold_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else begin
            for (int k = 9; k <= 10; k++) begin
                if (!keys_db[k]) begin
                    hold_cnt[k] <= '0;
                end else if (tick && hold_cnt[k] != 8'hFF) begin
                    hold_cnt[k] <= hold_cnt[k] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        raise      = '0;
        raise_long = '0;
        for (int k = 1; k <= 8; k++) begin
            raise[k] = db_nxt[k] & ~keys_db[k];
        end
        // The counter is monotonic within a press and saturates at or above
        // HOLD_TICKS, so the "about to reach" match fires exactly once. A count
        // at or past HOLD_TICKS at release means the long event already went.
        for (int k = 9; k <= 10; k++) begin
            if (tick && keys_db[k] && db_nxt[k] && hold_cnt[k] == HOLD_M1) begin
                raise[k]      = 1'b1;
                raise_long[k] = 1'b1;
            end else if (keys_db[k] && !db_nxt[k] && hold_cnt[k] < HOLD_LIM) begin
                raise[k] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        raise      = db_nxt & ~keys_db;
        raise_long = '0;
    end
`endif

    // ------------------------------------------------------------------
    // Pending slots and lowest-index selection
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_nxt;
    logic [10:1] pending;
    logic [10:1] pend_long;
    logic [10:1] sel_mask;
    logic [3:0]  sel_code;
    logic        sel_long;
    logic        sel_found;
    logic        take;
    logic [10:1] clr_mask;
    logic [10:1] pend_eff;
    logic [10:1] accept;
    logic [10:1] drop;
    logic [3:0]  cur_code;
    logic        cur_long;

    always_comb begin
        sel_mask  = '0;
        sel_code  = 4'd0;
        sel_long  = 1'b0;
        sel_found = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (!sel_found && pending[k]) begin
                sel_found   = 1'b1;
                sel_mask[k] = 1'b1;
                sel_code    = 4'(k);
                sel_long    = pend_long[k];
            end
        end
    end

    // The slot being moved into PRESENT this cycle counts as free, so a key
    // firing again at that moment is queued rather than dropped.
    assign take     = (state == S_IDLE) && sel_found;
    assign clr_mask = take ? sel_mask : '0;
    assign pend_eff = pending & ~clr_mask;
    assign accept   = raise & ~pend_eff;
    assign drop     = raise & pend_eff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            pend_long <= '0;
            evt_ovf   <= 1'b0;
            cur_code  <= 4'd0;
            cur_long  <= 1'b0;
        end else begin
            pending   <= pend_eff | accept;
            pend_long <= (pend_long & ~accept) | (raise_long & accept);
            evt_ovf   <= |drop;
            if (take) begin
                cur_code <= sel_code;
                cur_long <= sel_long;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Returning to IDLE after every handshake guarantees one empty cycle
    // between consecutive events.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (take)      state_nxt = S_PRESENT;
            S_PRESENT: if (evt_ready) state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        evt_valid = 1'b0;
        evt_code  = 4'd0;
        evt_long  = 1'b0;
        if (state == S_PRESENT) begin
            evt_valid = 1'b1;
            evt_code  = cur_code;
            evt_long  = cur_long;
        end
    end

endmodule
